// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin datapath arbiter (mux_rr_arbiter).
package arb_pkg;

    localparam int NREQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit of req searching ptr, ptr+1, ptr+2, ptr+3 (wrapping).
    // Returns ptr when req is empty; callers only use the result when |req.
    function automatic idx_t rr_pick(logic [3:0] req, idx_t ptr);
        idx_t idx;
        rr_pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + idx_t'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(idx_t i);
        onehot = 4'b0001 << i;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux_4NtoN: combinational N-bit 4:1 mux with enable and active-low clear, no added latency.
module mux_4NtoN #(
    parameter int N = 24
) (
    input  logic [1:0]   S,
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic [N-1:0] I2,
    input  logic [N-1:0] I3,
    input  logic         en,
    input  logic         rst,
    output logic [N-1:0] Y
);

    always_comb begin
        Y = '0;
        if (en && rst) begin
            unique case (S)
                2'd0: Y = I0;
                2'd1: Y = I1;
                2'd2: Y = I2;
                default: Y = I3;
            endcase
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4NtoN among 4 requesters, valid/ready output.
// Optional burst locking is compiled in with `define ARB_LOCK_EN.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 24,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [3:0]   req,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
`ifdef ARB_LOCK_EN
    input  logic [3:0]   lock,
`endif
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output arb_state_t   dbg_state
);

    // Handshake: a word transfers in every cycle where out_valid & out_ready;
    // out_valid, gnt and out_data stay stable until that happens (or an abort).

    if (MAX_BURST < 1) begin : g_bad_max_burst
    end

    arb_state_t r_state;
    logic [3:0] r_gnt;
    idx_t       r_sel;
    idx_t       r_ptr;
    logic       r_valid;

    logic       w_accept;
    logic       w_abort;
    logic       w_hold_lock;
    logic [3:0] w_others;
    logic [3:0] w_req_nxt;
    idx_t       w_next_ptr;
    idx_t       w_pick_idle;
    idx_t       w_pick_rot;

`ifdef ARB_LOCK_EN
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    logic [BW-1:0] r_burst;
`endif

    always_comb begin
        w_accept    = (r_state == GRANT) && out_ready;
        w_abort     = (r_state == GRANT) && !out_ready && !req[r_sel];
        w_next_ptr  = r_sel + 2'd1;
        w_others    = req & ~onehot(r_sel);
        // The served requester drops out of the next pick unless nobody else is asking.
        w_req_nxt   = (w_others != 4'b0000) ? w_others : req;
`ifdef ARB_LOCK_EN
        if (lock[r_sel]) w_req_nxt = req;
        w_hold_lock = w_accept && lock[r_sel] && req[r_sel] && (r_burst < BURST_LAST);
`else
        w_hold_lock = 1'b0;
`endif
        w_pick_idle = rr_pick(req, r_ptr);
        w_pick_rot  = rr_pick(w_req_nxt, w_next_ptr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_valid <= 1'b0;
`ifdef ARB_LOCK_EN
            r_burst <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (en && (req != 4'b0000)) begin
                        r_state <= GRANT;
                        r_sel   <= w_pick_idle;
                        r_gnt   <= onehot(w_pick_idle);
                        r_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_hold_lock) begin
`ifdef ARB_LOCK_EN
                        r_burst <= r_burst + 1'b1;
`endif
                    end else if (w_accept || w_abort) begin
`ifdef ARB_LOCK_EN
                        r_burst <= '0;
`endif
                        r_ptr <= w_next_ptr;
                        if (en && (w_req_nxt != 4'b0000)) begin
                            r_sel <= w_pick_rot;
                            r_gnt <= onehot(w_pick_rot);
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mux_4NtoN #(.N(N)) u_mux (
        .S   (r_sel),
        .I0  (d0),
        .I1  (d1),
        .I2  (d2),
        .I3  (d3),
        .en  (1'b1),
        .rst (1'b1),
        .Y   (out_data)
    );

    assign gnt       = r_gnt;
    assign ack       = r_gnt & {4{out_ready}};
    assign out_valid = r_valid;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: reset, vector table, directed corner sequences, random vs model.
module tb_mux_rr_arbiter;
    import arb_pkg::*;

    localparam int N = 24;
`ifdef ARB_LOCK_EN
    localparam int MB = 3;
`else
    localparam int MB = 4;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         out_ready;
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic         out_valid;
    logic [N-1:0] d [4];
    logic [N-1:0] out_data;
    arb_state_t   dbg_state;
`ifdef ARB_LOCK_EN
    logic [3:0]   lock;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: owner index (-1 = idle), rotation pointer, burst length.
    bit model_on = 1'b0;
    int m_owner;
    int m_ptr;
    int m_burst;

    typedef struct {
        logic [3:0]   req;
        logic         en;
        logic         rdy;
        logic [3:0]   gnt;
        logic         vld;
        logic [N-1:0] data;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_update();
        bit acc;
        bit abt;
        bit keep;
        if (m_owner < 0) begin
            if (en && req != 4'b0000) m_owner = pick(req, m_ptr);
        end else begin
            acc  = out_ready;
            abt  = !out_ready && !req[m_owner];
            keep = 1'b0;
`ifdef ARB_LOCK_EN
            keep = acc && lock[m_owner] && req[m_owner] && (m_burst < MB - 1);
`endif
            if (keep) begin
                m_burst++;
            end else if (acc || abt) begin
                m_burst = 0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = (en && req != 4'b0000) ? pick(req, m_ptr) : -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (model_on) model_update();
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'(d[0]));
        step();
        chk("rst_hold_gnt", 32'(gnt), 32'h0);
        rst = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_burst = 0;
    endtask

    initial begin
        logic [3:0] lock_exp [7];
        rst = 1'b1;
        en = 1'b1;
        req = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 24'hA0 + 24'(i);
`ifdef ARB_LOCK_EN
        lock = 4'b0000;
`endif
        // reset with all requesting, first grant one cycle after release
        @(posedge clk);
        #1;
        do_reset();
        step();
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        chk("rst_first_valid", 32'(out_valid), 32'h1);

        // fairness and enable behaviour as a vector table
        tbl[0] = '{4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 24'h0};
        tbl[1] = '{4'hF, 1'b1, 1'b1, 4'b0001, 1'b1, 24'hA0};
        tbl[2] = '{4'hF, 1'b1, 1'b1, 4'b0010, 1'b1, 24'hA1};
        tbl[3] = '{4'hF, 1'b1, 1'b1, 4'b0100, 1'b1, 24'hA2};
        tbl[4] = '{4'hF, 1'b1, 1'b1, 4'b1000, 1'b1, 24'hA3};
        tbl[5] = '{4'hF, 1'b1, 1'b1, 4'b0001, 1'b1, 24'hA0};
        tbl[6] = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 24'hA0};
        tbl[7] = '{4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 24'h0};
        tbl[8] = '{4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 24'h0};
        tbl[9] = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 24'hA1};
        req = 4'hF;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            en = tbl[i].en;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].data));
        end

        // backpressure on a single requester; req drops with the final accept
        en = 1'b1;
        req = 4'b0100;
        d[2] = 24'h33;
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_gnt", 32'(gnt), 32'h4);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data), 32'h33);
            chk("bp_ack", 32'(ack), 32'h0);
        end
        out_ready = 1'b1;
        req = 4'b0000;
        #1;
        chk("bp_ack_final", 32'(ack), 32'h4);
        step();
        chk("bp_idle_gnt", 32'(gnt), 32'h0);
        chk("bp_idle_valid", 32'(out_valid), 32'h0);
        chk("bp_idle_state", 32'(dbg_state), 32'(IDLE));

        // abort: requester 1 withdraws before being accepted
        req = 4'b0010;
        out_ready = 1'b0;
        do_reset();
        step();
        chk("abort_gnt1", 32'(gnt), 32'h2);
        req = 4'b1000;
        #1;
        chk("abort_no_ack", 32'(ack), 32'h0);
        step();
        chk("abort_gnt3", 32'(gnt), 32'h8);
        out_ready = 1'b1;
        #1;
        chk("abort_ack3", 32'(ack), 32'h8);
        step();

`ifdef ARB_LOCK_EN
        // lock on requester 2 with MAX_BURST=3, pointer brought to 2 first
        req = 4'b0010;
        lock = 4'b0000;
        out_ready = 1'b1;
        do_reset();
        step();
        chk("lock_pre_gnt", 32'(gnt), 32'h2);
        req = 4'hF;
        lock = 4'b0100;
        lock_exp = '{4'h4, 4'h4, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("lock%0d_gnt", i), 32'(gnt), 32'(lock_exp[i]));
        end
        lock = 4'b0000;
`endif

        // random traffic against the reference model
        req = 4'h0;
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 500; c++) begin
            req = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
            en = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef ARB_LOCK_EN
            lock = 4'($urandom_range(0, 15));
`endif
            for (int i = 0; i < 4; i++)
                if (i != m_owner) d[i] = N'($urandom);
            #1;
            chk("rnd_ack", 32'(ack), (m_owner >= 0 && out_ready) ? (32'h1 << m_owner) : 32'h0);
            step();
            chk("rnd_gnt", 32'(gnt), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
            chk("rnd_valid", 32'(out_valid), (m_owner >= 0) ? 32'h1 : 32'h0);
            if (m_owner >= 0) chk("rnd_data", 32'(out_data), 32'(d[m_owner]));
        end
        model_on = 1'b0;

        // asynchronous reset in the middle of a held grant
        req = 4'hF;
        en = 1'b1;
        out_ready = 1'b0;
        step();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
